// File: rtl/mis_dem_pkg.sv
// rtl/mis_dem_pkg.sv - shared encodings for the MIS DEM sequencing controller
package mis_dem_pkg;

   localparam int N_ELEM_DEF = 18;

   typedef enum logic [1:0] {
      DEM_THERMO = 2'b00,
      DEM_SHAPE  = 2'b01,
      DEM_DWA    = 2'b10
   } dem_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WARM  = 3'd1,
      ST_SHAPE = 3'd2,
      ST_FLUSH = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

endpackage

// File: rtl/mis_dem_dwa_ptr.sv
// rtl/mis_dem_dwa_ptr.sv - modulo-N_ELEM rotation pointer for DWA fallback selection
module mis_dem_dwa_ptr
   import mis_dem_pkg::*;
#(
   parameter int N_ELEM = N_ELEM_DEF
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       clr,
   input  logic       adv,
   input  logic [4:0] sd_cnt,
   output logic [4:0] ptr
);

   logic [5:0] sum;
   logic [4:0] ptr_nxt;

   // sd_cnt never exceeds N_ELEM, so one conditional subtract wraps the sum
   always_comb begin
      sum     = {1'b0, ptr} + {1'b0, sd_cnt};
      ptr_nxt = (sum >= 6'(N_ELEM)) ? 5'(sum - 6'(N_ELEM)) : sum[4:0];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/mis_dem_ctrl.sv
// rtl/mis_dem_ctrl.sv - warm-up/shape/flush/hold sequencer for the MIS shaping loop filter
// Optional DWA fallback selection: define MIS_DEM_DWA_FALLBACK_EN.
module mis_dem_ctrl
   import mis_dem_pkg::*;
#(
   parameter int N_ELEM    = N_ELEM_DEF,
   parameter int WARM_CYC  = 64,
   parameter int OVLD_TH   = 24,
   parameter int OVLD_CYC  = 4,
   parameter int FLUSH_CYC = 4,
   parameter int HOLD_CYC  = 256,
   parameter int TMR_W     = 9
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic       force_thermo,
   input  logic [6:0] sfm_peak,
   input  logic [4:0] sd_cnt,
   output logic       lf_rstn,
   output logic [1:0] dem_mode,
   output logic       busy,
   output logic [7:0] ovld_cnt,
   output logic [4:0] dwa_ptr
);

   localparam int RUN_W = $clog2(OVLD_CYC + 1);

`ifdef MIS_DEM_DWA_FALLBACK_EN
   localparam dem_mode_t FALLBACK = DEM_DWA;
`else
   localparam dem_mode_t FALLBACK = DEM_THERMO;
`endif

   state_t            state, state_nxt;
   logic [TMR_W-1:0]  tmr, tmr_nxt;
   logic [RUN_W-1:0]  run, run_nxt;
   logic              ovld_evt;

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      run_nxt   = run;
      ovld_evt  = 1'b0;
      if (!en) begin
         state_nxt = ST_IDLE;
         tmr_nxt   = '0;
         run_nxt   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_WARM;
               tmr_nxt   = TMR_W'(WARM_CYC - 1);
            end
            ST_WARM: begin
               if (tmr == '0) begin
                  state_nxt = ST_SHAPE;
                  run_nxt   = '0;
               end else begin
                  tmr_nxt = tmr - TMR_W'(1);
               end
            end
            ST_SHAPE: begin
               // run counts consecutive over-threshold samples only
               if (sfm_peak >= 7'(OVLD_TH)) begin
                  if (run == RUN_W'(OVLD_CYC - 1)) begin
                     state_nxt = ST_FLUSH;
                     tmr_nxt   = TMR_W'(FLUSH_CYC - 1);
                     run_nxt   = '0;
                     ovld_evt  = 1'b1;
                  end else begin
                     run_nxt = run + RUN_W'(1);
                  end
               end else begin
                  run_nxt = '0;
               end
            end
            ST_FLUSH: begin
               if (tmr == '0) begin
                  state_nxt = ST_HOLD;
                  tmr_nxt   = TMR_W'(HOLD_CYC - 1);
               end else begin
                  tmr_nxt = tmr - TMR_W'(1);
               end
            end
            ST_HOLD: begin
               if (tmr == '0) begin
                  state_nxt = ST_SHAPE;
                  run_nxt   = '0;
               end else begin
                  tmr_nxt = tmr - TMR_W'(1);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // outputs are decoded from state_nxt so they switch on the same edge as the state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         tmr      <= '0;
         run      <= '0;
         ovld_cnt <= '0;
         lf_rstn  <= 1'b0;
         dem_mode <= DEM_THERMO;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         tmr      <= tmr_nxt;
         run      <= run_nxt;
         if (ovld_evt && (ovld_cnt != 8'hff)) begin
            ovld_cnt <= ovld_cnt + 8'd1;
         end
         lf_rstn  <= !(state_nxt inside {ST_IDLE, ST_FLUSH});
         busy     <= (state_nxt inside {ST_FLUSH, ST_HOLD});
         if (force_thermo) begin
            dem_mode <= DEM_THERMO;
         end else if (state_nxt == ST_SHAPE) begin
            dem_mode <= DEM_SHAPE;
         end else begin
            dem_mode <= FALLBACK;
         end
      end
   end

`ifdef MIS_DEM_DWA_FALLBACK_EN
   mis_dem_dwa_ptr #(
      .N_ELEM (N_ELEM)
   ) u_dwa_ptr (
      .clk    (clk),
      .rstn   (rstn),
      .clr    ((state_nxt == ST_IDLE) && (state != ST_IDLE)),
      .adv    ((dem_mode == DEM_DWA) && !force_thermo),
      .sd_cnt (sd_cnt),
      .ptr    (dwa_ptr)
   );
`else
   logic unused_sd;
   assign unused_sd = (^sd_cnt) ^ (N_ELEM == 0);
   assign dwa_ptr   = '0;
`endif

endmodule
